// File: rtl/if_id_multi_reg_pkg.sv
// Shared core definitions: NOP encoding, default widths, slot counting helper.
// Latency: none (package only).
// Backpressure: not applicable.
package core_pkg;

  localparam int MAX_LANES   = 4;
  localparam int DEF_LANES   = 2;
  localparam int DEF_PC_W    = 6;
  localparam int DEF_INSTR_W = 32;

  // Zero instruction doubles as the pipeline bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Number of occupied slots in a prefix-shaped valid vector (leading run of ones).
  function automatic logic [2:0] popcount_prefix(input logic [MAX_LANES-1:0] v);
    logic [2:0] cnt;
    logic       run;
    cnt = 3'd0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (run && v[i]) begin
        cnt = cnt + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/if_id_multi_reg_if.sv
// Fetch/decode bus for the multi-slot IF/ID register.
// Latency: none (wires only).
// Backpressure: acceptF low tells fetch to hold its group; issueD reports decode consumption.
interface if_id_multi_reg_if #(
  parameter int LANES   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 6,
  parameter int CNT_W   = 16
);
  localparam int IW = $clog2(LANES + 1);

  logic [LANES*INSTR_W-1:0] instructionF;
  logic [LANES*PC_W-1:0]    pcF;
  logic [LANES*PC_W-1:0]    pcPlus1F;
  logic [LANES-1:0]         validF;
  logic [IW-1:0]            issueD;
  logic                     stall;
  logic                     flush;

  logic [LANES*INSTR_W-1:0] instructionD;
  logic [LANES*PC_W-1:0]    pcD;
  logic [LANES*PC_W-1:0]    pcPlus1D;
  logic [LANES-1:0]         validD;
  logic                     acceptF;
  logic [CNT_W-1:0]         splitCount;

  // Fetch/decode/hazard side.
  modport master (
    output instructionF, pcF, pcPlus1F, validF, issueD, stall, flush,
    input  instructionD, pcD, pcPlus1D, validD, acceptF, splitCount
  );

  // Pipeline register side.
  modport slave (
    input  instructionF, pcF, pcPlus1F, validF, issueD, stall, flush,
    output instructionD, pcD, pcPlus1D, validD, acceptF, splitCount
  );
endinterface

// File: rtl/if_id_slot_shift.sv
// Compaction mux: drops the first eff slots and moves the remainder down to slot 0.
// Latency: combinational.
// Backpressure: none; vacated upper slots are filled with invalid zero bubbles.
module if_id_slot_shift import core_pkg::*; #(
  parameter int LANES   = DEF_LANES,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int IW      = $clog2(LANES + 1)
) (
  input  logic [IW-1:0]            eff,
  input  logic [LANES*INSTR_W-1:0] instr_in,
  input  logic [LANES*PC_W-1:0]    pc_in,
  input  logic [LANES*PC_W-1:0]    pcp1_in,
  input  logic [LANES-1:0]         valid_in,
  output logic [LANES*INSTR_W-1:0] instr_out,
  output logic [LANES*PC_W-1:0]    pc_out,
  output logic [LANES*PC_W-1:0]    pcp1_out,
  output logic [LANES-1:0]         valid_out
);

  // Slot j takes slot j+eff; sources past the top leave the zero default in place.
  always_comb begin
    instr_out = {LANES{INSTR_W'(NOP_INSTR)}};
    pc_out    = '0;
    pcp1_out  = '0;
    valid_out = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int k = 0; k < LANES; k++) begin
        if (k == j + int'(eff)) begin
          instr_out[j*INSTR_W +: INSTR_W] = instr_in[k*INSTR_W +: INSTR_W];
          pc_out[j*PC_W +: PC_W]          = pc_in[k*PC_W +: PC_W];
          pcp1_out[j*PC_W +: PC_W]        = pcp1_in[k*PC_W +: PC_W];
          valid_out[j]                    = valid_in[k];
        end
      end
    end
  end

endmodule

// File: rtl/if_id_multi_reg.sv
// Multi-slot IF/ID pipeline register with partial issue (leftover slots shift down).
// Latency: 1 cycle from the accepting edge to the D outputs.
// Backpressure: acceptF drops while unissued slots remain, on stall, flush or reset.
module if_id_multi_reg import core_pkg::*; #(
  parameter int LANES   = DEF_LANES,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  if_id_multi_reg_if.slave bus
);

  localparam int IW = $clog2(LANES + 1);

  logic [LANES*INSTR_W-1:0] instr_q, instr_load, instr_shift;
  logic [LANES*PC_W-1:0]    pc_q, pc_load, pc_shift;
  logic [LANES*PC_W-1:0]    pcp1_q, pcp1_load, pcp1_shift;
  logic [LANES-1:0]         valid_q, valid_load, valid_shift;
  logic [CNT_W-1:0]         split_q;
  logic [IW-1:0]            vcnt, eff, rem;
  logic                     accept;

  // Occupancy, clamped issue count and leftover count.
  always_comb begin
    vcnt   = IW'(popcount_prefix(MAX_LANES'(valid_q)));
    eff    = (bus.issueD > vcnt) ? vcnt : bus.issueD;
    rem    = vcnt - eff;
    accept = ~reset & ~bus.flush & ~bus.stall & (rem == '0);
  end

  // Fetch group with invalid slots forced to zero bubbles.
  always_comb begin
    instr_load = {LANES{INSTR_W'(NOP_INSTR)}};
    pc_load    = '0;
    pcp1_load  = '0;
    valid_load = bus.validF;
    for (int i = 0; i < LANES; i++) begin
      if (bus.validF[i]) begin
        instr_load[i*INSTR_W +: INSTR_W] = bus.instructionF[i*INSTR_W +: INSTR_W];
        pc_load[i*PC_W +: PC_W]          = bus.pcF[i*PC_W +: PC_W];
        pcp1_load[i*PC_W +: PC_W]        = bus.pcPlus1F[i*PC_W +: PC_W];
      end
    end
  end

  if_id_slot_shift #(
    .LANES   (LANES),
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .IW      (IW)
  ) u_shift (
    .eff       (eff),
    .instr_in  (instr_q),
    .pc_in     (pc_q),
    .pcp1_in   (pcp1_q),
    .valid_in  (valid_q),
    .instr_out (instr_shift),
    .pc_out    (pc_shift),
    .pcp1_out  (pcp1_shift),
    .valid_out (valid_shift)
  );

  // Slot registers and split counter: reset > flush > stall > load/shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      pcp1_q  <= '0;
      valid_q <= '0;
      split_q <= '0;
    end else if (bus.flush) begin
      instr_q <= '0;
      pc_q    <= '0;
      pcp1_q  <= '0;
      valid_q <= '0;
    end else if (!bus.stall) begin
      if (rem == '0) begin
        instr_q <= instr_load;
        pc_q    <= pc_load;
        pcp1_q  <= pcp1_load;
        valid_q <= valid_load;
      end else begin
        // With eff == 0 the shifter returns the current contents unchanged.
        instr_q <= instr_shift;
        pc_q    <= pc_shift;
        pcp1_q  <= pcp1_shift;
        valid_q <= valid_shift;
        if ((eff != '0) && (split_q != '1)) begin
          split_q <= split_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.instructionD = instr_q;
  assign bus.pcD          = pc_q;
  assign bus.pcPlus1D     = pcp1_q;
  assign bus.validD       = valid_q;
  assign bus.acceptF      = accept;
  assign bus.splitCount   = split_q;

endmodule

// File: tb/tb_if_id_multi_reg.sv
// Bench for the multi-slot IF/ID register: dual-lane and single-lane builds in parallel.
// Latency: expectations are pushed per cycle and popped by a monitor half a cycle later.
// Backpressure: reference model tracks leftover slots as a queue of instructions.
module tb_if_id_multi_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  pc;
    logic [5:0]  pcp1;
  } slot_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic [63:0] instr;
    logic [11:0] pc;
    logic [11:0] pcp1;
    logic [3:0]  cnt;
    logic        acc;
    logic        v1;
    logic [31:0] i1;
    logic [5:0]  p1;
    logic [5:0]  pp1;
    logic        acc1;
  } exp_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  exp_t  sbq[$];
  slot_t mq[$];       // dual-lane model: slots still waiting for decode, oldest first
  int    mcnt = 0;    // dual-lane model split counter
  slot_t m1;          // single-lane model slot
  bit    m1v = 1'b0;

  if_id_multi_reg_if #(.LANES(2), .INSTR_W(32), .PC_W(6), .CNT_W(4)) bus ();
  if_id_multi_reg_if #(.LANES(1), .INSTR_W(32), .PC_W(6), .CNT_W(4)) bus1 ();

  if_id_multi_reg #(.LANES(2), .INSTR_W(32), .PC_W(6), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  if_id_multi_reg #(.LANES(1), .INSTR_W(32), .PC_W(6), .CNT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Single-lane build sees slot 0 of the same stimulus.
  assign bus1.instructionF = bus.instructionF[31:0];
  assign bus1.pcF          = bus.pcF[5:0];
  assign bus1.pcPlus1F     = bus.pcPlus1F[5:0];
  assign bus1.validF       = bus.validF[0];
  assign bus1.issueD       = (bus.issueD != 2'd0);
  assign bus1.stall        = bus.stall;
  assign bus1.flush        = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic slot_t mk(input logic [31:0] i, input logic [5:0] p);
    slot_t s;
    s.instr = i;
    s.pc    = p;
    s.pcp1  = p + 6'd1;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    return mk($urandom, 6'($urandom_range(0, 63)));
  endfunction

  // Drive one cycle, queue the expected view, then advance the model past the edge.
  task automatic step(input bit rst, input bit fl, input bit st, input logic [1:0] iss,
                      input logic [1:0] vf, input slot_t g0, input slot_t g1);
    exp_t e;
    int   eff;
    int   rem;
    bit   e1;
    bit   r1;
    reset            = rst;
    bus.flush        = fl;
    bus.stall        = st;
    bus.issueD       = iss;
    bus.validF       = vf;
    bus.instructionF = {g1.instr, g0.instr};
    bus.pcF          = {g1.pc, g0.pc};
    bus.pcPlus1F     = {g1.pcp1, g0.pcp1};
    assert (vf != 2'b10) else $error("validF not a prefix: %b", vf);

    e = '0;
    for (int i = 0; i < 2; i++) begin
      if (i < mq.size()) begin
        e.valid[i]           = 1'b1;
        e.instr[i*32 +: 32]  = mq[i].instr;
        e.pc[i*6 +: 6]       = mq[i].pc;
        e.pcp1[i*6 +: 6]     = mq[i].pcp1;
      end
    end
    e.cnt = 4'(mcnt);
    eff   = (int'(iss) < mq.size()) ? int'(iss) : mq.size();
    rem   = mq.size() - eff;
    e.acc = !rst && !fl && !st && (rem == 0);
    e.v1  = m1v;
    e.i1  = m1v ? m1.instr : 32'h0;
    e.p1  = m1v ? m1.pc : 6'h0;
    e.pp1 = m1v ? m1.pcp1 : 6'h0;
    e1     = (iss != 2'd0) && m1v;
    r1     = m1v && !e1;
    e.acc1 = !rst && !fl && !st && !r1;
    sbq.push_back(e);

    if (rst) begin
      mq.delete();
      mcnt = 0;
      m1v  = 1'b0;
    end else if (fl) begin
      mq.delete();
      m1v = 1'b0;
    end else if (!st) begin
      if (rem == 0) begin
        mq.delete();
        if (vf[0]) mq.push_back(g0);
        if (vf[1]) mq.push_back(g1);
      end else begin
        repeat (eff) void'(mq.pop_front());
        if (eff > 0 && mcnt < 15) mcnt++;
      end
      if (!r1) begin
        m1v = vf[0];
        m1  = g0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUTs present their registered state and acceptF.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("validD",        64'(bus.validD),       64'(e.valid));
        check("instructionD",  64'(bus.instructionD), e.instr);
        check("pcD",           64'(bus.pcD),          64'(e.pc));
        check("pcPlus1D",      64'(bus.pcPlus1D),     64'(e.pcp1));
        check("splitCount",    64'(bus.splitCount),   64'(e.cnt));
        check("acceptF",       64'(bus.acceptF),      64'(e.acc));
        check("l1_validD",     64'(bus1.validD),       64'(e.v1));
        check("l1_instructionD", 64'(bus1.instructionD), 64'(e.i1));
        check("l1_pcD",        64'(bus1.pcD),          64'(e.p1));
        check("l1_pcPlus1D",   64'(bus1.pcPlus1D),     64'(e.pp1));
        check("l1_splitCount", 64'(bus1.splitCount),   64'(0));
        check("l1_acceptF",    64'(bus1.acceptF),      64'(e.acc1));
      end
    end
  end

  initial begin
    slot_t a, b, c, d, ee, f, g, h;
    bit    rst, fl, st;
    int    k;
    a  = mk(32'hA000_0001, 6'd4);
    b  = mk(32'hB000_0002, 6'd5);
    c  = mk(32'hC000_0003, 6'd8);
    d  = mk(32'hD000_0004, 6'd9);
    ee = mk(32'hE000_0005, 6'd12);
    f  = mk(32'hF000_0006, 6'd13);
    g  = mk(32'h1234_5678, 6'd20);
    h  = mk(32'h8765_4321, 6'd21);

    // First reset edge with arbitrary inputs; nothing is known before it.
    reset            = 1'b1;
    bus.flush        = 1'b0;
    bus.stall        = 1'b0;
    bus.issueD       = 2'd2;
    bus.validF       = 2'b11;
    bus.instructionF = {$urandom, $urandom};
    bus.pcF          = 12'($urandom);
    bus.pcPlus1F     = 12'($urandom);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 2'd1, 2'b11, rnd_slot(), rnd_slot());

    // Load, full issue, partial issue, stall, stall+flush, clamp, empty group.
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'b11, a, b);
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'b11, c, d);
    step(1'b0, 1'b0, 1'b0, 2'd1, 2'b11, ee, f);
    step(1'b0, 1'b0, 1'b0, 2'd1, 2'b11, ee, f);
    step(1'b0, 1'b0, 1'b1, 2'd2, 2'b11, g, h);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'b11, g, h);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'b01, g, h);
    step(1'b0, 1'b0, 1'b0, 2'd2, 2'b00, rnd_slot(), rnd_slot());
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'b11, a, b);

    // Twenty partial issues drive the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd1, 2'b11, rnd_slot(), rnd_slot());
      step(1'b0, 1'b0, 1'b0, 2'd1, 2'b11, rnd_slot(), rnd_slot());
    end

    // Mid-operation reset, then random traffic.
    step(1'b1, 1'b0, 1'b0, 2'd1, 2'b11, rnd_slot(), rnd_slot());
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      fl  = ($urandom_range(0, 99) < 6);
      st  = ($urandom_range(0, 99) < 15);
      k   = $urandom_range(0, 2);
      step(rst, fl, st, 2'($urandom_range(0, 3) % 3), 2'((1 << k) - 1), rnd_slot(), rnd_slot());
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'b00, rnd_slot(), rnd_slot());

    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
